// File: rtl/bp_ctrl.sv
// ---------------------------------------------------------------------------
// bp_ctrl -- branch predictor controller for a single-port 2-bit-counter BHT.
//
// Serves direction lookups from fetch and applies committed branch outcomes
// from the ROB through a small update FIFO. After reset the whole table is
// written to weakly-not-taken (2'b01) before any lookup is accepted.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   en                  global enable, 0 freezes every register
//   iIF_Req/iIF_Pc      fetch lookup request (held until oIF_Ack) and its PC
//   oIF_Ack/oIF_Taken   one-cycle acknowledge and predicted direction
//   iRob_En/Pc/Taken    committed branch outcome offered to the update queue
//   oRob_Full           update queue full (outcomes offered now are dropped)
//   oRdy                table initialisation complete
//   oTb_En/We/Idx/Wd    registered access to the BHT
//   iTb_Rd              BHT read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module bp_ctrl #(
    parameter int IDX_W    = 6,
    parameter int UQ_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             iIF_Req,
    input  logic [31:0]      iIF_Pc,
    output logic             oIF_Ack,
    output logic             oIF_Taken,
    input  logic             iRob_En,
    input  logic [31:0]      iRob_Pc,
    input  logic             iRob_Taken,
    output logic             oRob_Full,
    output logic             oRdy,
    output logic             oTb_En,
    output logic             oTb_We,
    output logic [IDX_W-1:0] oTb_Idx,
    output logic [1:0]       oTb_Wd,
    input  logic [1:0]       iTb_Rd
);

    localparam int PTR_W = $clog2(UQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(UQ_DEPTH);
    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    typedef enum logic [2:0] {INIT, IDLE, L_RD, L_RSP, U_RD, U_RSP} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   init_idx_q, init_idx_d;
    logic               ack_q, ack_d;
    logic               taken_q, taken_d;
    logic               rdy_q, rdy_d;
    logic               tb_en_q, tb_en_d;
    logic               tb_we_q, tb_we_d;
    logic [IDX_W-1:0]   tb_idx_q, tb_idx_d;
    logic [1:0]         tb_wd_q, tb_wd_d;
    logic               upd_tkn_q, upd_tkn_d;

    // Update queue: storage plus pointers/count
    logic [IDX_W-1:0]   uq_idx_q [UQ_DEPTH];
    logic               uq_tkn_q [UQ_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               full, empty, enq, deq;

    // Only the table-index bits of the PCs matter here
    logic unused_pc_bits;
    assign unused_pc_bits = ^{iIF_Pc[31:IDX_W+2], iIF_Pc[1:0],
                              iRob_Pc[31:IDX_W+2], iRob_Pc[1:0]};

    // Saturating 2-bit counter step
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end
        return (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    endfunction

    assign full  = (cnt_q == CNT_FULL);
    assign empty = (cnt_q == '0);
    // Fullness is judged before this edge's dequeue, so an outcome offered
    // while full is dropped even if a slot frees on the same edge.
    assign enq   = iRob_En && !full;

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        ack_d      = 1'b0;
        taken_d    = taken_q;
        rdy_d      = rdy_q;
        tb_en_d    = 1'b0;
        tb_we_d    = 1'b0;
        tb_idx_d   = tb_idx_q;
        tb_wd_d    = tb_wd_q;
        upd_tkn_d  = upd_tkn_q;
        deq        = 1'b0;
        case (state_q)
            INIT: begin
                tb_en_d    = 1'b1;
                tb_we_d    = 1'b1;
                tb_idx_d   = init_idx_q;
                tb_wd_d    = 2'b01;
                init_idx_d = init_idx_q + IDX_W'(1);
                if (init_idx_q == IDX_LAST) begin
                    state_d = IDLE;
                    rdy_d   = 1'b1;
                end
            end
            IDLE: begin
                // A full queue wins so updates cannot starve behind fetch.
                // The !ack_q term stops a still-held request from being
                // taken twice in the cycle its acknowledge is visible.
                if (full) begin
                    deq       = 1'b1;
                    tb_en_d   = 1'b1;
                    tb_idx_d  = uq_idx_q[rd_ptr_q];
                    upd_tkn_d = uq_tkn_q[rd_ptr_q];
                    state_d   = U_RD;
                end else if (iIF_Req && !ack_q) begin
                    tb_en_d  = 1'b1;
                    tb_idx_d = iIF_Pc[IDX_W+1:2];
                    state_d  = L_RD;
                end else if (!empty) begin
                    deq       = 1'b1;
                    tb_en_d   = 1'b1;
                    tb_idx_d  = uq_idx_q[rd_ptr_q];
                    upd_tkn_d = uq_tkn_q[rd_ptr_q];
                    state_d   = U_RD;
                end
            end
            L_RD:  state_d = L_RSP;
            L_RSP: begin
                ack_d   = 1'b1;
                taken_d = iTb_Rd[1];
                state_d = IDLE;
            end
            U_RD:  state_d = U_RSP;
            U_RSP: begin
                tb_en_d = 1'b1;
                tb_we_d = 1'b1;
                tb_wd_d = sat_update(iTb_Rd, upd_tkn_q);
                state_d = IDLE;
            end
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        wr_ptr_d = enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (enq && !deq) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!enq && deq) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= INIT;
            init_idx_q <= '0;
            ack_q      <= 1'b0;
            taken_q    <= 1'b0;
            rdy_q      <= 1'b0;
            tb_en_q    <= 1'b0;
            tb_we_q    <= 1'b0;
            tb_idx_q   <= '0;
            tb_wd_q    <= '0;
            upd_tkn_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else if (en) begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            ack_q      <= ack_d;
            taken_q    <= taken_d;
            rdy_q      <= rdy_d;
            tb_en_q    <= tb_en_d;
            tb_we_q    <= tb_we_d;
            tb_idx_q   <= tb_idx_d;
            tb_wd_q    <= tb_wd_d;
            upd_tkn_q  <= upd_tkn_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en && enq) begin
            uq_idx_q[wr_ptr_q] <= iRob_Pc[IDX_W+1:2];
            uq_tkn_q[wr_ptr_q] <= iRob_Taken;
        end
    end

    assign oIF_Ack   = ack_q;
    assign oIF_Taken = taken_q;
    assign oRdy      = rdy_q;
    assign oRob_Full = full;
    // A held enable must not reach the table while the block is frozen
    assign oTb_En    = tb_en_q & en;
    assign oTb_We    = tb_we_q;
    assign oTb_Idx   = tb_idx_q;
    assign oTb_Wd    = tb_wd_q;

endmodule

// File: tb/tb_bp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bp_ctrl -- directed self-checking bench for bp_ctrl (IDX_W=6, depth 4).
// A behavioural single-port BHT answers the table port and logs every
// read index and every write {idx, data} for later inspection.
// ---------------------------------------------------------------------------
module tb_bp_ctrl;

    localparam int IDX_W    = 6;
    localparam int UQ_DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst, en;
    logic             iIF_Req;
    logic [31:0]      iIF_Pc;
    logic             oIF_Ack, oIF_Taken;
    logic             iRob_En;
    logic [31:0]      iRob_Pc;
    logic             iRob_Taken;
    logic             oRob_Full, oRdy;
    logic             oTb_En, oTb_We;
    logic [IDX_W-1:0] oTb_Idx;
    logic [1:0]       oTb_Wd;
    logic [1:0]       tb_rd = 2'b00;

    bp_ctrl #(.IDX_W(IDX_W), .UQ_DEPTH(UQ_DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .iIF_Req   (iIF_Req),
        .iIF_Pc    (iIF_Pc),
        .oIF_Ack   (oIF_Ack),
        .oIF_Taken (oIF_Taken),
        .iRob_En   (iRob_En),
        .iRob_Pc   (iRob_Pc),
        .iRob_Taken(iRob_Taken),
        .oRob_Full (oRob_Full),
        .oRdy      (oRdy),
        .oTb_En    (oTb_En),
        .oTb_We    (oTb_We),
        .oTb_Idx   (oTb_Idx),
        .oTb_Wd    (oTb_Wd),
        .iTb_Rd    (tb_rd)
    );

    always #5 clk = ~clk;

    // BHT model with access logs
    logic [1:0]       bht [64];
    logic [7:0]       wlog [$];
    logic [IDX_W-1:0] rlog [$];

    always @(posedge clk) begin
        if (oTb_En === 1'b1) begin
            if (oTb_We === 1'b1) begin
                bht[oTb_Idx] <= oTb_Wd;
                wlog.push_back({oTb_Idx, oTb_Wd});
            end else begin
                tb_rd <= bht[oTb_Idx];
                rlog.push_back(oTb_Idx);
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] wget(input int i);
        if (i < wlog.size()) return wlog[i];
        return 8'hFF;
    endfunction

    function automatic logic [5:0] rget(input int i);
        if (i < rlog.size()) return rlog[i];
        return 6'h3F;
    endfunction

    // Advance one clock; return on the falling edge where outputs are stable
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Lookup from IDLE with an empty queue; checks issue, latency and pulse
    task automatic do_lookup(input logic [31:0] pc, input logic [5:0] idx,
                             input logic exp_tkn, input string tag);
        iIF_Req = 1'b1;
        iIF_Pc  = pc;
        step();
        chk({tag, "_rd_en"},  32'(oTb_En),  1);
        chk({tag, "_rd_we"},  32'(oTb_We),  0);
        chk({tag, "_rd_idx"}, 32'(oTb_Idx), 32'(idx));
        step();
        chk({tag, "_ack_n1"}, 32'(oIF_Ack), 0);
        step();
        chk({tag, "_ack"},    32'(oIF_Ack),   1);
        chk({tag, "_taken"},  32'(oIF_Taken), 32'(exp_tkn));
        iIF_Req = 1'b0;
        step();
        chk({tag, "_pulse"},  32'(oIF_Ack),   0);
        chk({tag, "_hold"},   32'(oIF_Taken), 32'(exp_tkn));
    endtask

    task automatic send_upd(input logic [31:0] pc, input logic tk, input int n);
        iRob_En    = 1'b1;
        iRob_Pc    = pc;
        iRob_Taken = tk;
        repeat (n) step();
        iRob_En    = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] fill_pc [5] = '{32'h30, 32'h20, 32'h20, 32'h20, 32'h40};
    logic        fill_tk [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin : stim
        int good;
        int waited;
        int acks;
        logic ack_tkn;

        rst = 1'b0; en = 1'b0;
        iIF_Req = 1'b0; iIF_Pc = '0;
        iRob_En = 1'b0; iRob_Pc = '0; iRob_Taken = 1'b0;

        // Reset while disabled must still clear everything
        repeat (2) step();
        chk("rst_rdy",   32'(oRdy),      0);
        chk("rst_ack",   32'(oIF_Ack),   0);
        chk("rst_taken", 32'(oIF_Taken), 0);
        chk("rst_full",  32'(oRob_Full), 0);
        chk("rst_we",    32'(oTb_We),    0);
        chk("rst_idx",   32'(oTb_Idx),   0);
        chk("rst_wd",    32'(oTb_Wd),    0);
        en = 1'b1;
        step();
        chk("rst_tb_en", 32'(oTb_En), 0);
        rst = 1'b1;

        // Initialisation: 64 consecutive writes of 01
        good = 0;
        for (int c = 0; c < 64; c++) begin
            step();
            if (oTb_En === 1'b1 && oTb_We === 1'b1 && oTb_Idx === 6'(c) && oTb_Wd === 2'b01)
                good++;
            if (c == 62) chk("init_rdy_early", 32'(oRdy), 0);
        end
        chk("init_writes", good, 64);
        step();
        chk("init_rdy",  32'(oRdy),   1);
        chk("init_idle", 32'(oTb_En), 0);

        // First lookup: PC 0x10 -> idx 4, counter 01 -> not taken
        do_lookup(32'h10, 6'd4, 1'b0, "lk1");

        // Two taken updates: 01 -> 10 -> 11
        wlog.delete();
        send_upd(32'h10, 1'b1, 2);
        repeat (12) step();
        chk("upd2_n",  wlog.size(), 2);
        chk("upd2_w0", 32'(wget(0)), 32'h12);
        chk("upd2_w1", 32'(wget(1)), 32'h13);
        do_lookup(32'h10, 6'd4, 1'b1, "lk2");

        // Another taken update saturates at 11
        wlog.delete();
        send_upd(32'h10, 1'b1, 1);
        repeat (8) step();
        chk("upd_sat_n",  wlog.size(), 1);
        chk("upd_sat_w0", 32'(wget(0)), 32'h13);

        // Freeze for 5 cycles in L_RD; ROB offers during the freeze are ignored
        wlog.delete();
        iIF_Req = 1'b1;
        iIF_Pc  = 32'h14;
        step();
        chk("en_rd_en",  32'(oTb_En),  1);
        chk("en_rd_idx", 32'(oTb_Idx), 5);
        en = 1'b0;
        iRob_En = 1'b1; iRob_Pc = 32'h14; iRob_Taken = 1'b1;
        good = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (oTb_En === 1'b0 && oIF_Ack === 1'b0 && oTb_Idx === 6'd5 && oTb_We === 1'b0)
                good++;
        end
        chk("en_hold", good, 5);
        iRob_En = 1'b0;
        en = 1'b1;
        step();
        chk("en_ack_early", 32'(oIF_Ack), 0);
        step();
        chk("en_ack",   32'(oIF_Ack),   1);
        chk("en_taken", 32'(oIF_Taken), 0);
        iIF_Req = 1'b0;
        step();
        chk("en_pulse", 32'(oIF_Ack), 0);
        repeat (8) step();
        chk("en_rob_ignored", wlog.size(), 0);

        // Reset while an update sits in U_RSP with more queued behind it
        send_upd(32'h50, 1'b1, 3);
        rst = 1'b0;
        wlog.delete();
        rlog.delete();
        step();
        chk("r2_tb_en", 32'(oTb_En),    0);
        chk("r2_rdy",   32'(oRdy),      0);
        chk("r2_full",  32'(oRob_Full), 0);
        rst = 1'b1;

        // Fill the queue during INIT with a lookup held pending
        repeat (3) step();
        iIF_Req = 1'b1;
        iIF_Pc  = 32'h30;
        for (int k = 0; k < 5; k++) begin
            iRob_En    = 1'b1;
            iRob_Pc    = fill_pc[k];
            iRob_Taken = fill_tk[k];
            step();
            chk($sformatf("fill_full_%0d", k), 32'(oRob_Full), (k >= 3) ? 1 : 0);
        end
        iRob_En = 1'b0;
        chk("init_no_ack", 32'(oIF_Ack), 0);

        waited = 0;
        while (oRdy !== 1'b1 && waited < 100) begin
            step();
            waited++;
        end
        chk("r2_rdy_seen", 32'(oRdy), 1);

        acks = 0;
        ack_tkn = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (oIF_Ack === 1'b1) begin
                acks++;
                ack_tkn = oIF_Taken;
                iIF_Req = 1'b0;
            end
        end
        iIF_Req = 1'b0;
        chk("fill_acks",  acks, 1);
        chk("fill_taken", 32'(ack_tkn), 1);

        // Write log: INIT from idx 0, then 12:10, then three 8:00
        chk("r2_first_w", 32'(wget(0)), 32'h01);
        good = 0;
        for (int i = 0; i < 64; i++)
            if (wget(i) === {6'(i), 2'b01}) good++;
        chk("r2_init_writes", good, 64);
        chk("fill_wn", wlog.size(), 68);
        chk("fill_w64", 32'(wget(64)), 32'h32);
        chk("fill_w65", 32'(wget(65)), 32'h20);
        chk("fill_w66", 32'(wget(66)), 32'h20);
        chk("fill_w67", 32'(wget(67)), 32'h20);
        // Reads: update of idx 12 first, then the lookup, then three updates
        chk("fill_rn",  rlog.size(), 5);
        chk("fill_r0",  32'(rget(0)), 12);
        chk("fill_r1",  32'(rget(1)), 12);
        chk("fill_r2",  32'(rget(2)), 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_ctrl.md
BP_CTRL -- requirements
Module: bp_ctrl

Interface
REQ-001 SHALL have parameter IDX_W, default 6: branch history table (BHT) index width, 2^IDX_W entries.
REQ-002 SHALL have parameter UQ_DEPTH, default 4: update queue depth, a power of two of at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port en, input, 1 bit: global enable; 0 freezes all state.
REQ-006 SHALL have port iIF_Req, input, 1 bit: fetch requests a prediction; held high until oIF_Ack.
REQ-007 SHALL have port iIF_Pc, input, 32 bits: fetch PC; valid while iIF_Req=1.
REQ-008 SHALL have port oIF_Ack, output, 1 bit: one-cycle pulse; prediction valid.
REQ-009 SHALL have port oIF_Taken, output, 1 bit: predicted direction; valid with oIF_Ack, held otherwise.
REQ-010 SHALL have port iRob_En, input, 1 bit: a committed branch outcome is offered.
REQ-011 SHALL have port iRob_Pc, input, 32 bits: PC of the committed branch.
REQ-012 SHALL have port iRob_Taken, input, 1 bit: actual direction of the committed branch.
REQ-013 SHALL have port oRob_Full, output, 1 bit: update queue holds UQ_DEPTH entries.
REQ-014 SHALL have port oRdy, output, 1 bit: table initialisation complete.
REQ-015 SHALL have table ports oTb_En (output, 1 bit), oTb_We (output, 1 bit), oTb_Idx (output, IDX_W bits), oTb_Wd (output, 2 bits) and iTb_Rd (input, 2 bits), all connecting to the single-port BHT.

Function
REQ-016 BHT access: one access per cycle; read data valid on iTb_Rd in the cycle after a read; the table holds iTb_Rd until its next read.
REQ-017 oTb_We, oTb_Idx and oTb_Wd SHALL be registered; oTb_En SHALL be a registered enable ANDed with en.
REQ-018 Index of any PC SHALL be pc[IDX_W+1:2].
REQ-019 States SHALL be INIT, IDLE, L_RD, L_RSP, U_RD and U_RSP.
REQ-020 INIT: write 2'b01 to index 0, 1, …, 2^IDX_W-1, one per cycle; after the last write go to IDLE and set oRdy=1; iIF_Req is not accepted during INIT.
REQ-021 Update queue: FIFO of {index, taken}; enqueue when iRob_En=1, en=1 and count<UQ_DEPTH.
REQ-022 iRob_En while full SHALL drop the entry, even if a dequeue occurs on the same edge.
REQ-023 oRob_Full SHALL equal (count==UQ_DEPTH) combinationally; the queue SHALL accept enqueues in every state, INIT included.
REQ-024 IDLE arbitration SHALL use the following priority:
  - first, if the queue is full, dequeue and go to U_RD;
  - else, if iIF_Req=1 and oIF_Ack=0, capture the iIF_Pc index and go to L_RD;
  - else, if the queue is not empty, dequeue and go to U_RD;
  - else, stay in IDLE.
REQ-025 Leaving IDLE SHALL register a read (oTb_En=1, oTb_We=0, oTb_Idx=captured index); otherwise oTb_En SHALL clear.
REQ-026 L_RD and U_RD SHALL clear oTb_En and advance to L_RSP and U_RSP respectively.
REQ-027 L_RSP SHALL set oIF_Ack=1 and oIF_Taken=iTb_Rd[1] for exactly one cycle, then return to IDLE.
REQ-028 Lookup latency: request accepted at edge N -> oIF_Ack high in the cycle after edge N+2.
REQ-029 U_RSP SHALL register a write (oTb_En=1, oTb_We=1, same index) and return to IDLE. oTb_Wd SHALL be the saturating update of iTb_Rd: taken -> min(cnt+1, 3); not taken -> max(cnt-1, 0).
REQ-030 A lookup to an index with a pending update SHALL return the current table value; no forwarding.
REQ-031 en=0 SHALL hold every register, including FIFO, state and outputs; iIF_Req and iRob_En SHALL be ignored; oTb_En SHALL be 0.

Reset
REQ-032 At a rising edge with rst=0, the block SHALL:
  - set state=INIT and INIT index=0;
  - empty the queue;
  - clear oIF_Ack, oIF_Taken, oRdy, oTb_En, oTb_We, oTb_Idx and oTb_Wd to 0.
REQ-033 Reset SHALL take effect regardless of en.
REQ-034 Reset during a lookup or update SHALL abandon it without acknowledge or write; queued updates SHALL be lost.

Verification
REQ-035 The bench SHALL cover reset, IDX_W=6 -> 64 consecutive writes of 01 to idx 0..63, then oRdy=1 on the following cycle.
REQ-036 The bench SHALL cover a lookup, iIF_Pc=0x00000010 after init -> read idx 4 issued, oIF_Ack=1 with oIF_Taken=0 after edge N+2, exactly one pulse.
REQ-037 The bench SHALL cover two taken updates for PC 0x10, then a lookup -> writes 10 then 11, oIF_Taken=1; further taken update keeps 11.
REQ-038 The bench SHALL cover filling the queue with 4 updates while iIF_Req is held -> oRob_Full=1; a 5th iRob_En is dropped; the update is serviced before the lookup; a not-taken at 00 stays 00.
REQ-039 The bench SHALL cover en=0 for 5 cycles in L_RD -> no state change, oTb_En=0; the ack arrives exactly 2 cycles after en returns to 1.
REQ-040 The bench SHALL cover rst=0 in U_RSP -> no write issued, queue empty, INIT restarts at idx 0.
